// File: rtl/axis_soft_mute.sv
// AXI-Stream soft mute: linear gain ramp between unity and zero, stepped once per stereo frame.
// Registered single-entry output stage, full throughput, 1-cycle latency.
module axis_soft_mute #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned RAMP_SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mute,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  muted,
  output logic                  ramping
);

  localparam int unsigned GW = RAMP_SHIFT + 1;
  localparam int unsigned PW = DATA_WIDTH + RAMP_SHIFT + 2;
  localparam logic [GW-1:0] GainUnity = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GW-1:0] GainZero  = '0;
  localparam logic [GW-1:0] GainOne   = {{RAMP_SHIFT{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StUnity,
    StRampDown,
    StMuted,
    StRampUp
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [GW-1:0]         r_gain;
  logic [GW-1:0]         w_gain_d;
  logic [GW-1:0]         w_gain_dec;
  logic [GW-1:0]         w_gain_inc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_muted;
  logic                  r_ramping;
  logic                  w_accept;
  logic                  w_frame;
  logic                  w_go_down;
  logic                  w_go_up;
  logic [PW-1:0]         w_data_ext;
  logic [PW-1:0]         w_gain_ext;
  logic [PW-1:0]         w_prod;

  assign s_axis_ready = !r_valid || m_axis_ready;
  assign w_accept     = s_axis_valid && s_axis_ready;
  assign w_frame      = w_accept && s_axis_last;

  // Gain is zero-extended so it multiplies as a non-negative signed operand.
  assign w_data_ext = {{(RAMP_SHIFT + 2){s_axis_data[DATA_WIDTH-1]}}, s_axis_data};
  assign w_gain_ext = {{(DATA_WIDTH + 1){1'b0}}, r_gain};
  assign w_prod     = $signed(w_data_ext) * $signed(w_gain_ext);

  assign w_gain_dec = r_gain - GainOne;
  assign w_gain_inc = r_gain + GainOne;

  always_comb begin
    w_state_d = r_state;
    w_gain_d  = r_gain;
    w_go_down = w_frame && mute && (r_state != StMuted);
    w_go_up   = w_frame && !mute && (r_state != StUnity);
    if (w_go_down) begin
      w_gain_d  = w_gain_dec;
      w_state_d = (w_gain_dec == GainZero) ? StMuted : StRampDown;
    end else if (w_go_up) begin
      w_gain_d  = w_gain_inc;
      w_state_d = (w_gain_inc == GainUnity) ? StUnity : StRampUp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StUnity;
      r_gain    <= GainUnity;
      r_muted   <= 1'b0;
      r_ramping <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_gain    <= w_gain_d;
      r_muted   <= (w_state_d == StMuted);
      r_ramping <= (w_state_d == StRampDown) || (w_state_d == StRampUp);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_prod[DATA_WIDTH+RAMP_SHIFT-1:RAMP_SHIFT];
      r_last  <= s_axis_last;
    end else if (m_axis_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_axis_data  = r_data;
  assign m_axis_valid = r_valid;
  assign m_axis_last  = r_last;
  assign muted        = r_muted;
  assign ramping      = r_ramping;

endmodule

// File: tb/tb_axis_soft_mute.sv
// Scoreboard bench for axis_soft_mute with RAMP_SHIFT=2 (unity gain 4) and hand-computed outputs.
module tb_axis_soft_mute;

  localparam int unsigned DW = 24;
  localparam int unsigned RS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mute = 1'b0;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic          s_axis_last = 1'b0;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready = 1'b1;
  logic          m_axis_last;
  logic          muted;
  logic          ramping;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW:0] exp_q[$];
  logic        rand_mode = 1'b0;
  logic        ready_val = 1'b1;
  logic        hold_pend = 1'b0;
  logic [DW:0] hold_val = '0;

  axis_soft_mute #(
    .DATA_WIDTH(DW),
    .RAMP_SHIFT(RS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mute        (mute),
    .s_axis_data (s_axis_data),
    .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready),
    .s_axis_last (s_axis_last),
    .m_axis_data (m_axis_data),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .m_axis_last (m_axis_last),
    .muted       (muted),
    .ramping     (ramping)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: pops one expected beat per output handshake; checks hold stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        n_total++;
        if ({m_axis_last, m_axis_data} !== hold_val) begin
          n_bad++;
          $display("FAIL stall_hold: got %h required %h", {m_axis_last, m_axis_data}, hold_val);
        end
      end
      if (m_axis_valid && m_axis_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat_extra: got %h with empty scoreboard", {m_axis_last, m_axis_data});
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({m_axis_last, m_axis_data} !== e) begin
            n_bad++;
            $display("FAIL beat: got last=%b data=%0d required last=%b data=%0d", m_axis_last,
                     $signed(m_axis_data), e[DW], $signed(e[DW-1:0]));
          end
        end
      end
      hold_pend <= m_axis_valid && !m_axis_ready;
      hold_val  <= {m_axis_last, m_axis_data};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_total++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic send(input int d, input logic last, input int e);
    logic got;
    got = 1'b0;
    s_axis_valid = 1'b1;
    s_axis_data  = DW'(d);
    s_axis_last  = last;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (s_axis_ready) begin
        exp_q.push_back({last, DW'(e)});
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_axis_valid = 1'b0;
    if (!got) begin
      n_total++;
      n_bad++;
      $display("FAIL send_timeout: got no ready required ready within 200 cycles");
    end
  endtask

  task automatic frame(input int l, input int r, input int el, input int er);
    send(l, 1'b0, el);
    if (rand_mode && $urandom_range(0, 1) == 1) begin
      @(posedge clk);
      #1;
    end
    send(r, 1'b1, er);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_axis_valid) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(m_axis_valid), 32'd0);
    check("rst_data", 32'(m_axis_data), 32'd0);
    check("rst_last", 32'(m_axis_last), 32'd0);
    check("rst_flags", {30'd0, muted, ramping}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Unity pass-through
    frame(32'h000400, 32'hFFFC00, 1024, -1024);
    frame(32'h000400, 32'hFFFC00, 1024, -1024);
    drain();
    check("t1_flags", {30'd0, muted, ramping}, 32'd0);

    // Ramp down to silence
    mute = 1'b1;
    frame(1024, -1024, 1024, -1024);
    check("t2_ramping", 32'(ramping), 32'd1);
    frame(1024, -1024, 768, -768);
    frame(1024, -1024, 512, -512);
    frame(1024, -1024, 256, -256);
    check("t2_muted", {30'd0, muted, ramping}, 32'd2);
    frame(1024, -1024, 0, 0);
    drain();
    check("t2_muted_hold", {30'd0, muted, ramping}, 32'd2);

    // Ramp up with negative floor rounding
    mute = 1'b0;
    frame(-3, -1, 0, 0);
    check("t3_rampup", {30'd0, muted, ramping}, 32'd1);
    frame(-3, -1024, -1, -256);
    frame(-1024, 5, -512, 2);
    frame(-1024, -3, -768, -3);
    drain();
    check("t3_unity", {30'd0, muted, ramping}, 32'd0);

    // Mute toggled with no traffic leaves gain at unity
    mute = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    mute = 1'b0;
    check("t4_idle_flags", {30'd0, muted, ramping}, 32'd0);
    frame(1024, 100, 1024, 100);

    // Partial ramp then reversal
    mute = 1'b1;
    frame(1024, 100, 1024, 100);
    frame(1024, 100, 768, 75);
    mute = 1'b0;
    frame(1024, 100, 512, 50);
    check("t4_ramping", 32'(ramping), 32'd1);
    frame(1024, 100, 768, 75);
    check("t4_unity", {30'd0, muted, ramping}, 32'd0);
    frame(1024, 100, 1024, 100);
    drain();

    // Full ramp under random backpressure and input gaps
    rand_mode = 1'b1;
    mute = 1'b1;
    frame(1000, -1000, 1000, -1000);
    frame(1000, -1000, 750, -750);
    frame(1000, -1000, 500, -500);
    frame(1000, -1000, 250, -250);
    mute = 1'b0;
    frame(1000, -1000, 0, 0);
    frame(1000, -1000, 250, -250);
    frame(1000, -1000, 500, -500);
    frame(1000, -1000, 750, -750);
    frame(1000, -1000, 1000, -1000);
    rand_mode = 1'b0;
    ready_val = 1'b1;
    drain();
    check("t5_unity", {30'd0, muted, ramping}, 32'd0);

    // Reset while mid-ramp with a buffered beat
    mute = 1'b1;
    frame(1024, -1024, 1024, -1024);
    frame(1024, -1024, 768, -768);
    frame(1024, -1024, 512, -512);
    drain();
    ready_val = 1'b0;
    @(posedge clk);
    #1;
    send(1024, 1'b0, 256);
    check("t6_buffered", 32'(m_axis_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(m_axis_valid), 32'd0);
    exp_q.delete();
    mute = 1'b0;
    ready_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_flags", {30'd0, muted, ramping}, 32'd0);
    frame(1024, -1024, 1024, -1024);
    drain();
    check("t6_flags_after", {30'd0, muted, ramping}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
